// File: rtl/burst_read_sequencer.sv
// Burst read address generator for the memory port, with a small output FIFO.
// mem_addr is driven by the registered current-address counter.
`default_nettype none

module burst_read_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [3:0]        stride,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [3:0]        stride_q, stride_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic              done_q, done_d;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              last_mem [DEPTH];

  logic issue;
  logic pop;
  logic is_final;

  // Full test uses the registered count only: a same-cycle pop never frees a slot.
  assign issue    = (state_q == S_RUN) && (count_q != CNT_W'(DEPTH));
  assign pop      = out_valid && out_ready;
  assign is_final = (remaining_q == LEN_W'(1));

  always_comb begin
    count_d = count_q;
    if (issue && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!issue && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    stride_d    = stride_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (len != '0)) begin
          cur_addr_d  = base_addr;
          remaining_d = len;
          stride_d    = stride;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          cur_addr_d  = cur_addr_q + {{(ADDR_W-4){1'b0}}, stride_q};
          remaining_d = remaining_q - LEN_W'(1);
          if (is_final) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (count_d == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      stride_q    <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      stride_q    <= stride_d;
      count_q     <= count_d;
      done_q      <= done_d;
      if (issue) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      data_mem[wr_ptr_q] <= mem_data;
      last_mem[wr_ptr_q] <= is_final;
    end
  end

  // Head outputs are forced to zero when empty so reset-time values are defined.
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? data_mem[rd_ptr_q] : '0;
  assign out_last  = out_valid ? last_mem[rd_ptr_q] : 1'b0;
  assign mem_addr  = cur_addr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_burst_read_sequencer.sv
// Self-checking bench for burst_read_sequencer using a loopback memory
// (mem_data = mem_addr), a vector table and hand-written corner sequences.
`default_nettype none

module tb_burst_read_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [7:0]  len;
  logic [3:0]  stride;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  burst_read_sequencer #(
    .ADDR_W(16), .DATA_W(16), .LEN_W(8), .DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .len(len), .stride(stride), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  assign mem_data = mem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      base;
    logic [7:0]       len;
    logic [3:0]       stride;
    logic [3:0][15:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the command in cycle 0; returns positioned in cycle 1.
  task automatic start_burst(input logic [15:0] b, input logic [7:0] l, input logic [3:0] s);
    start     = 1'b1;
    base_addr = b;
    len       = l;
    stride    = s;
    tick();
    start = 1'b0;
  endtask

  // Scoreboard: pops every word, checks order, single out_last and single done.
  task automatic collect(input logic [15:0] b, input int n, input logic [3:0] s,
                         input bit rnd, input string tag);
    logic [15:0] exp_w;
    int got, lasts, dones, cyc;
    exp_w = b;
    got = 0; lasts = 0; dones = 0; cyc = 0;
    while (dones == 0 && cyc < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        chk({tag, "_data"}, {16'h0, out_data}, {16'h0, exp_w});
        if (out_last) begin
          lasts++;
          chk({tag, "_last_pos"}, got, n - 1);
        end
        exp_w = exp_w + {12'h0, s};
        got++;
      end
      if (done) begin
        dones++;
        chk({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
      end
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    chk({tag, "_words"}, got, n);
    chk({tag, "_lasts"}, lasts, 1);
    chk({tag, "_dones"}, dones, 1);
    chk({tag, "_done_one_cycle"}, {31'h0, done}, 32'h0);
    chk({tag, "_idle_after"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    stride    = '0;
    out_ready = 1'b1;

    vecs[0] = '{16'h0010, 8'd4, 4'd1,  {16'h0013, 16'h0012, 16'h0011, 16'h0010}};
    vecs[1] = '{16'hFFFE, 8'd3, 4'd1,  {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFE}};
    vecs[2] = '{16'hFFF8, 8'd2, 4'd15, {16'h0000, 16'h0000, 16'h0007, 16'hFFF8}};
    vecs[3] = '{16'h1234, 8'd1, 4'd5,  {16'h0000, 16'h0000, 16'h0000, 16'h1234}};
    vecs[4] = '{16'h0100, 8'd4, 4'd0,  {16'h0100, 16'h0100, 16'h0100, 16'h0100}};
    vecs[5] = '{16'h00F0, 8'd4, 4'd15, {16'h011D, 16'h010E, 16'h00FF, 16'h00F0}};

    #1;
    chk("rst_mem_addr",  {16'h0, mem_addr}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data",  {16'h0, out_data}, 32'h0);
    chk("rst_out_last",  {31'h0, out_last}, 32'h0);
    chk("rst_busy",      {31'h0, busy}, 32'h0);
    chk("rst_done",      {31'h0, done}, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Table: exact cycle-by-cycle timing with out_ready held high
    for (int v = 0; v < 6; v++) begin
      start_burst(vecs[v].base, vecs[v].len, vecs[v].stride);
      chk("vec_busy_c1", {31'h0, busy}, 32'h1);
      chk("vec_addr_c1", {16'h0, mem_addr}, {16'h0, vecs[v].base});
      tick();
      for (int k = 0; k < int'(vecs[v].len); k++) begin
        chk("vec_valid", {31'h0, out_valid}, 32'h1);
        chk("vec_data",  {16'h0, out_data}, {16'h0, vecs[v].exp[k]});
        chk("vec_last",  {31'h0, out_last}, {31'h0, (k == int'(vecs[v].len) - 1)});
        tick();
      end
      chk("vec_done",      {31'h0, done}, 32'h1);
      chk("vec_busy_done", {31'h0, busy}, 32'h0);
      chk("vec_valid_end", {31'h0, out_valid}, 32'h0);
      tick();
      chk("vec_done_pulse", {31'h0, done}, 32'h0);
    end

    // len=0 command is ignored
    start_burst(16'h0AAA, 8'd0, 4'd1);
    chk("len0_busy", {31'h0, busy}, 32'h0);
    tick();
    chk("len0_busy2",  {31'h0, busy}, 32'h0);
    chk("len0_valid",  {31'h0, out_valid}, 32'h0);

    // Second start while busy is ignored
    start_burst(16'h0200, 8'd3, 4'd1);
    start     = 1'b1;
    base_addr = 16'h0300;
    len       = 8'd2;
    tick();
    start = 1'b0;
    collect(16'h0200, 3, 4'd1, 1'b0, "busy_start");

    // Start in the done cycle begins the next burst immediately
    start_burst(16'h0400, 8'd2, 4'd1);
    for (int i = 0; i < 20 && !done; i++) tick();
    chk("dc_done_seen", {31'h0, done}, 32'h1);
    start_burst(16'h0410, 8'd1, 4'd0);
    chk("dc_busy",  {31'h0, busy}, 32'h1);
    chk("dc_addr",  {16'h0, mem_addr}, 32'h0410);
    collect(16'h0410, 1, 4'd0, 1'b0, "done_cycle");

    // Backpressure: exactly DEPTH issues, then stall
    out_ready = 1'b0;
    start_burst(16'h0500, 8'd8, 4'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("bp_addr_stall", {16'h0, mem_addr}, 32'h0504);
    chk("bp_valid",      {31'h0, out_valid}, 32'h1);
    chk("bp_head",       {16'h0, out_data}, 32'h0500);
    chk("bp_busy",       {31'h0, busy}, 32'h1);
    collect(16'h0500, 8, 4'd1, 1'b0, "backpressure");

    // Asynchronous reset mid-burst
    start_burst(16'h0600, 8'd8, 4'd1);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_mem_addr",  {16'h0, mem_addr}, 32'h0);
    chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_out_data",  {16'h0, out_data}, 32'h0);
    chk("arst_out_last",  {31'h0, out_last}, 32'h0);
    chk("arst_busy",      {31'h0, busy}, 32'h0);
    chk("arst_done",      {31'h0, done}, 32'h0);
    tick();
    #2;
    reset = 1'b1;
    tick();
    chk("arst_no_done", {31'h0, done}, 32'h0);
    tick();
    start_burst(16'h0100, 8'd2, 4'd1);
    collect(16'h0100, 2, 4'd1, 1'b0, "after_reset");

    // Random bursts with random backpressure
    for (int r = 0; r < 100; r++) begin
      logic [15:0] rb;
      logic [7:0]  rl;
      logic [3:0]  rs;
      rb = 16'($urandom);
      rl = 8'($urandom_range(1, 12));
      rs = 4'($urandom_range(0, 15));
      start_burst(rb, rl, rs);
      collect(rb, int'(rl), rs, 1'b1, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
